// File: rtl/noc_vc_link_mux.sv
// rtl/noc_vc_link_mux.sv - per-VC FIFOs merged onto one NoC link by a ready-aware round-robin arbiter
//
// Purpose: buffers each virtual channel in its own FIFO and grants the shared link to one
// VC per cycle. A VC is eligible when its FIFO is non-empty and its downstream ready is high.
// Eligible VCs are searched from the round-robin pointer upward.
//
// Ports:
//   clk            system clock
//   rst_sys        synchronous active-high reset
//   in_flit        VC v flit at [v*flit_width +: flit_width]
//   in_valid       per-VC input valid
//   in_ready       per-VC input ready (FIFO not full)
//   noc_out_flit   shared link flit, zero when idle
//   noc_out_valid  one-hot valid of the granted VC, zero when idle
//   noc_out_ready  per-VC downstream ready
//
// Optional feature: define NOC_VC_MUX_PACKET_LOCK_EN to hold the grant on a VC from a HEADER
// until its LAST, and to advance the round-robin pointer only on LAST or SINGLE flits.

module noc_vc_link_mux #(
  parameter int noc_flit_data_width = 32,
  parameter int noc_flit_type_width = 2,
  parameter int vchannels           = 3,
  parameter int fifo_depth          = 4
) (
  input  logic                                                        clk,
  input  logic                                                        rst_sys,
  input  logic [vchannels*(noc_flit_data_width+noc_flit_type_width)-1:0] in_flit,
  input  logic [vchannels-1:0]                                        in_valid,
  output logic [vchannels-1:0]                                        in_ready,
  output logic [noc_flit_data_width+noc_flit_type_width-1:0]          noc_out_flit,
  output logic [vchannels-1:0]                                        noc_out_valid,
  input  logic [vchannels-1:0]                                        noc_out_ready
);

  localparam int fw = noc_flit_data_width + noc_flit_type_width;
  localparam int aw = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam int cw = $clog2(fifo_depth) + 1;
  localparam int pw = (vchannels > 1) ? $clog2(vchannels) : 1;

  logic [fw-1:0]        mem   [vchannels][fifo_depth];
  logic [aw-1:0]        wptr  [vchannels];
  logic [aw-1:0]        rptr  [vchannels];
  logic [cw-1:0]        count [vchannels];
  logic [pw-1:0]        rr_ptr;
  logic [pw-1:0]        rr_next;
  logic [vchannels-1:0] push;
  logic [vchannels-1:0] pop;
  logic [vchannels-1:0] eligible;
  logic                 grant_valid;
  logic [pw-1:0]        grant_idx;
  logic [fw-1:0]        head_flit;

`ifdef NOC_VC_MUX_PACKET_LOCK_EN
  localparam logic [noc_flit_type_width-1:0] typ_header = noc_flit_type_width'(1);
  localparam logic [noc_flit_type_width-1:0] typ_last   = noc_flit_type_width'(2);
  localparam logic [noc_flit_type_width-1:0] typ_single = noc_flit_type_width'(3);

  logic                           locked;
  logic [pw-1:0]                  lock_vc;
  logic [noc_flit_type_width-1:0] head_type;

  assign head_type = head_flit[fw-1 -: noc_flit_type_width];
`endif

  // Ready never looks at pops: a full FIFO refuses input even while it is draining.
  always_comb begin
    in_ready = '0;
    push     = '0;
    eligible = '0;
    for (int v = 0; v < vchannels; v++) begin
      in_ready[v] = !rst_sys && (count[v] != cw'(fifo_depth));
      push[v]     = in_valid[v] && in_ready[v];
      eligible[v] = !rst_sys && (count[v] != '0) && noc_out_ready[v];
`ifdef NOC_VC_MUX_PACKET_LOCK_EN
      if (locked && (lock_vc != pw'(v))) begin
        eligible[v] = 1'b0;
      end
`endif
    end
  end

  // Walk offsets from high to low so the lowest offset from rr_ptr wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int i = vchannels - 1; i >= 0; i--) begin
      automatic int k = int'(rr_ptr) + i;
      if (k >= vchannels) begin
        k = k - vchannels;
      end
      if (eligible[k]) begin
        grant_valid = 1'b1;
        grant_idx   = pw'(k);
      end
    end
  end

  always_comb begin
    head_flit     = mem[grant_idx][rptr[grant_idx]];
    noc_out_flit  = grant_valid ? head_flit : '0;
    noc_out_valid = grant_valid ? (vchannels'(1) << grant_idx) : '0;
    pop           = noc_out_valid;
    rr_next       = (grant_idx == pw'(vchannels - 1)) ? '0 : grant_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    for (int v = 0; v < vchannels; v++) begin
      if (push[v]) begin
        mem[v][wptr[v]] <= in_flit[v*fw +: fw];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_sys) begin
      for (int v = 0; v < vchannels; v++) begin
        wptr[v]  <= '0;
        rptr[v]  <= '0;
        count[v] <= '0;
      end
      rr_ptr <= '0;
    end else begin
      for (int v = 0; v < vchannels; v++) begin
        if (push[v]) begin
          wptr[v] <= wptr[v] + 1'b1;
        end
        if (pop[v]) begin
          rptr[v] <= rptr[v] + 1'b1;
        end
        case ({push[v], pop[v]})
          2'b10:   count[v] <= count[v] + 1'b1;
          2'b01:   count[v] <= count[v] - 1'b1;
          default: count[v] <= count[v];
        endcase
      end
`ifdef NOC_VC_MUX_PACKET_LOCK_EN
      if (grant_valid && ((head_type == typ_last) || (head_type == typ_single))) begin
        rr_ptr <= rr_next;
      end
`else
      if (grant_valid) begin
        rr_ptr <= rr_next;
      end
`endif
    end
  end

`ifdef NOC_VC_MUX_PACKET_LOCK_EN
  // Only the locked VC can be granted, so a LAST seen while locked always ends that packet.
  always_ff @(posedge clk) begin
    if (rst_sys) begin
      locked  <= 1'b0;
      lock_vc <= '0;
    end else if (grant_valid) begin
      if (head_type == typ_header) begin
        locked  <= 1'b1;
        lock_vc <= grant_idx;
      end else if (head_type == typ_last) begin
        locked <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_noc_vc_link_mux.sv
// tb/tb_noc_vc_link_mux.sv - scoreboard bench for noc_vc_link_mux

module tb_noc_vc_link_mux;

  logic         clk = 1'b0;
  logic         rst_sys;
  logic [101:0] in_flit;
  logic [2:0]   in_valid;
  logic [2:0]   in_ready;
  logic [33:0]  noc_out_flit;
  logic [2:0]   noc_out_valid;
  logic [2:0]   noc_out_ready;

  typedef struct {
    int          cyc;
    logic [2:0]  v;
    logic [33:0] f;
  } obs_t;

  obs_t        obs_q [$];
  logic [33:0] exp_q [3][$];
  int          checks = 0;
  int          failures = 0;
  int          cycle_n = 0;
  obs_t        o;
  int          vc;
  logic [33:0] e;
  logic [33:0] fl;

  noc_vc_link_mux dut (
    .clk           (clk),
    .rst_sys       (rst_sys),
    .in_flit       (in_flit),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .noc_out_flit  (noc_out_flit),
    .noc_out_valid (noc_out_valid),
    .noc_out_ready (noc_out_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle_n <= cycle_n + 1;

  always @(negedge clk) begin
    if (!rst_sys && noc_out_valid != 3'b000) begin
      obs_q.push_back('{cycle_n, noc_out_valid, noc_out_flit});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_sys       = 1'b1;
    in_valid      = 3'b000;
    noc_out_ready = 3'b000;
    cyc();
    cyc();
    rst_sys = 1'b0;
    obs_q.delete();
    for (int v = 0; v < 3; v++) exp_q[v].delete();
  endtask

  task automatic test_reset();
    rst_sys       = 1'b1;
    in_valid      = 3'b111;
    in_flit       = {3{34'h3_1234_5678}};
    noc_out_ready = 3'b111;
    cyc();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 3'b000) begin
        failures++;
        $display("FAIL reset_in_ready cycle%0d got=%b required=000", i, in_ready);
      end
      checks++;
      if (noc_out_valid !== 3'b000 || noc_out_flit !== 34'h0) begin
        failures++;
        $display("FAIL reset_out cycle%0d valid=%b flit=%h required 000/0", i, noc_out_valid, noc_out_flit);
      end
      cyc();
    end
    rst_sys  = 1'b0;
    in_valid = 3'b000;
    @(negedge clk);
    checks++;
    if (in_ready !== 3'b111) begin
      failures++;
      $display("FAIL reset_release_ready got=%b required=111", in_ready);
    end
    checks++;
    if (noc_out_valid !== 3'b000) begin
      failures++;
      $display("FAIL reset_release_valid got=%b required=000", noc_out_valid);
    end
    cyc();
  endtask

  task automatic test_latency();
    apply_reset();
    noc_out_ready = 3'b111;
    in_flit = '0;
    in_flit[34 +: 34] = 34'h1_0000_00AA;
    in_valid = 3'b010;
    @(negedge clk);
    checks++;
    if (noc_out_valid !== 3'b000) begin
      failures++;
      $display("FAIL latency_same_cycle valid=%b required=000", noc_out_valid);
    end
    cyc();
    in_flit[34 +: 34] = 34'h2_0000_00BB;
    @(negedge clk);
    checks++;
    if (noc_out_valid !== 3'b010 || noc_out_flit !== 34'h1_0000_00AA) begin
      failures++;
      $display("FAIL latency_t1 valid=%b flit=%h required 010/1000000aa", noc_out_valid, noc_out_flit);
    end
    cyc();
    in_valid = 3'b000;
    @(negedge clk);
    checks++;
    if (noc_out_valid !== 3'b010 || noc_out_flit !== 34'h2_0000_00BB) begin
      failures++;
      $display("FAIL latency_second valid=%b flit=%h required 010/2000000bb", noc_out_valid, noc_out_flit);
    end
    cyc();
    cyc();
    obs_q.delete();
  endtask

  task automatic test_fairness();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      for (int v = 0; v < 3; v++) begin
        fl = {2'b11, 32'(v * 256 + i)};
        in_flit[v*34 +: 34] = fl;
        exp_q[v].push_back(fl);
      end
      in_valid = 3'b111;
      cyc();
    end
    in_valid = 3'b000;
    noc_out_ready = 3'b111;
    repeat (14) cyc();
    checks++;
    if (obs_q.size() != 12) begin
      failures++;
      $display("FAIL fair_count transfers=%0d required=12", obs_q.size());
    end
    for (int i = 0; obs_q.size() > 0; i++) begin
      o = obs_q.pop_front();
      vc = (o.v == 3'b001) ? 0 : (o.v == 3'b010) ? 1 : (o.v == 3'b100) ? 2 : -1;
      checks++;
      if (vc != i % 3) begin
        failures++;
        $display("FAIL fair_order idx%0d vc=%0d required=%0d", i, vc, i % 3);
      end
      if (i > 0 && obs_q.size() > 0) begin
        checks++;
        if (obs_q[0].cyc != o.cyc + 1) begin
          failures++;
          $display("FAIL fair_bubble idx%0d next_cycle=%0d required=%0d", i, obs_q[0].cyc, o.cyc + 1);
        end
      end
      if (vc >= 0 && exp_q[vc].size() > 0) begin
        e = exp_q[vc].pop_front();
        checks++;
        if (o.f !== e) begin
          failures++;
          $display("FAIL fair_data vc%0d flit=%h required=%h", vc, o.f, e);
        end
      end
    end
    for (int v = 0; v < 3; v++) begin
      checks++;
      if (exp_q[v].size() != 0) begin
        failures++;
        $display("FAIL fair_missing vc%0d left=%0d required=0", v, exp_q[v].size());
      end
    end
  endtask

  task automatic test_backpressure();
    int vc0_seen;
    apply_reset();
    noc_out_ready = 3'b110;
    for (int i = 0; i < 4; i++) begin
      for (int v = 0; v < 3; v++) begin
        fl = {2'b11, 32'((v + 1) * 32'h100 + i)};
        in_flit[v*34 +: 34] = fl;
        exp_q[v].push_back(fl);
      end
      in_valid = 3'b111;
      cyc();
    end
    in_valid = 3'b001;
    in_flit[0 +: 34] = 34'h3_DEAD_BEEF;
    @(negedge clk);
    checks++;
    if (in_ready[0] !== 1'b0) begin
      failures++;
      $display("FAIL bp_full_ready got=%b required=0", in_ready[0]);
    end
    checks++;
    if (in_ready[2:1] !== 2'b11) begin
      failures++;
      $display("FAIL bp_other_ready got=%b required=11", in_ready[2:1]);
    end
    vc0_seen = 0;
    foreach (obs_q[i]) if (obs_q[i].v[0]) vc0_seen++;
    checks++;
    if (obs_q.size() < 3 || vc0_seen != 0) begin
      failures++;
      $display("FAIL bp_others_flow transfers=%0d vc0=%0d required >=3 and 0", obs_q.size(), vc0_seen);
    end
    cyc();
    in_valid = 3'b000;
    noc_out_ready = 3'b111;
    repeat (12) cyc();
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      vc = (o.v == 3'b001) ? 0 : (o.v == 3'b010) ? 1 : (o.v == 3'b100) ? 2 : -1;
      checks++;
      if (vc < 0) begin
        failures++;
        $display("FAIL bp_onehot valid=%b required one-hot", o.v);
      end else if (exp_q[vc].size() == 0) begin
        failures++;
        $display("FAIL bp_extra vc%0d flit=%h required none", vc, o.f);
      end else begin
        e = exp_q[vc].pop_front();
        if (o.f !== e) begin
          failures++;
          $display("FAIL bp_data vc%0d flit=%h required=%h", vc, o.f, e);
        end
      end
    end
    for (int v = 0; v < 3; v++) begin
      checks++;
      if (exp_q[v].size() != 0) begin
        failures++;
        $display("FAIL bp_missing vc%0d left=%0d required=0", v, exp_q[v].size());
      end
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    in_flit = '0;
    for (int i = 0; i < 5; i++) begin
      fl = {2'b11, 32'(32'hC0 + i)};
      in_flit[68 +: 34] = fl;
      exp_q[2].push_back(fl);
      in_valid = 3'b100;
      noc_out_ready = (i == 3) ? 3'b100 : 3'b000;
      @(negedge clk);
      if (i == 3) begin
        checks++;
        if (in_ready[2] !== 1'b1 || noc_out_valid !== 3'b100) begin
          failures++;
          $display("FAIL simul_both ready=%b valid=%b required 1/100", in_ready[2], noc_out_valid);
        end
      end
      if (i == 4) begin
        checks++;
        if (in_ready[2] !== 1'b1) begin
          failures++;
          $display("FAIL simul_count_kept ready=%b required=1", in_ready[2]);
        end
      end
      cyc();
    end
    in_valid = 3'b000;
    @(negedge clk);
    checks++;
    if (in_ready[2] !== 1'b0) begin
      failures++;
      $display("FAIL simul_full ready=%b required=0", in_ready[2]);
    end
    cyc();
    noc_out_ready = 3'b100;
    repeat (6) cyc();
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      checks++;
      if (o.v !== 3'b100 || exp_q[2].size() == 0) begin
        failures++;
        $display("FAIL simul_extra valid=%b flit=%h required vc2 expected flit", o.v, o.f);
      end else begin
        e = exp_q[2].pop_front();
        if (o.f !== e) begin
          failures++;
          $display("FAIL simul_data flit=%h required=%h", o.f, e);
        end
      end
    end
    checks++;
    if (exp_q[2].size() != 0) begin
      failures++;
      $display("FAIL simul_missing left=%0d required=0", exp_q[2].size());
    end
  endtask

  task automatic test_lock();
    logic [2:0] exp_stall;
    int         ord [4];
`ifdef NOC_VC_MUX_PACKET_LOCK_EN
    exp_stall = 3'b000;
    ord = '{0, 0, 0, 1};
`else
    exp_stall = 3'b010;
    ord = '{0, 1, 0, 0};
`endif
    apply_reset();
    in_flit = '0;
    in_flit[0 +: 34]  = 34'h1_0000_0A01;
    in_flit[34 +: 34] = 34'h3_0000_0B01;
    exp_q[0].push_back(34'h1_0000_0A01);
    exp_q[1].push_back(34'h3_0000_0B01);
    in_valid = 3'b011;
    cyc();
    in_flit[0 +: 34] = 34'h0_0000_0A02;
    exp_q[0].push_back(34'h0_0000_0A02);
    in_valid = 3'b001;
    cyc();
    in_flit[0 +: 34] = 34'h2_0000_0A03;
    exp_q[0].push_back(34'h2_0000_0A03);
    cyc();
    in_valid = 3'b000;
    noc_out_ready = 3'b011;
    @(negedge clk);
    checks++;
    if (noc_out_valid !== 3'b001 || noc_out_flit !== 34'h1_0000_0A01) begin
      failures++;
      $display("FAIL lock_header valid=%b flit=%h required 001/100000a01", noc_out_valid, noc_out_flit);
    end
    cyc();
    noc_out_ready = 3'b010;
    @(negedge clk);
    checks++;
    if (noc_out_valid !== exp_stall) begin
      failures++;
      $display("FAIL lock_stall valid=%b required=%b", noc_out_valid, exp_stall);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (noc_out_valid !== 3'b000) begin
      failures++;
      $display("FAIL lock_stall2 valid=%b required=000", noc_out_valid);
    end
    cyc();
    noc_out_ready = 3'b011;
    repeat (5) cyc();
    checks++;
    if (obs_q.size() != 4) begin
      failures++;
      $display("FAIL lock_count transfers=%0d required=4", obs_q.size());
    end
    for (int i = 0; i < 4 && obs_q.size() > 0; i++) begin
      o = obs_q.pop_front();
      vc = (o.v == 3'b001) ? 0 : (o.v == 3'b010) ? 1 : (o.v == 3'b100) ? 2 : -1;
      checks++;
      if (vc != ord[i]) begin
        failures++;
        $display("FAIL lock_order idx%0d vc=%0d required=%0d", i, vc, ord[i]);
      end else if (exp_q[vc].size() == 0) begin
        failures++;
        $display("FAIL lock_extra vc%0d flit=%h required none", vc, o.f);
      end else begin
        e = exp_q[vc].pop_front();
        if (o.f !== e) begin
          failures++;
          $display("FAIL lock_data vc%0d flit=%h required=%h", vc, o.f, e);
        end
      end
    end
  endtask

  initial begin
    rst_sys       = 1'b1;
    in_flit       = '0;
    in_valid      = 3'b000;
    noc_out_ready = 3'b000;
    test_reset();
    test_latency();
    test_fairness();
    test_backpressure();
    test_simultaneous();
    test_lock();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
